// File: rtl/rformat_pkg.sv
// Shared ALU operation encodings for the R-format execute/writeback unit.
package rformat_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] alu_op_t;

    localparam alu_op_t OP_AND = 3'b000;
    localparam alu_op_t OP_OR  = 3'b001;
    localparam alu_op_t OP_ADD = 3'b010;
    localparam alu_op_t OP_XOR = 3'b011;
    localparam alu_op_t OP_NOR = 3'b100;
    localparam alu_op_t OP_RSV = 3'b101;
    localparam alu_op_t OP_SUB = 3'b110;
    localparam alu_op_t OP_SLT = 3'b111;

endpackage

// File: rtl/rformat_exec_unit_if.sv
// Instruction-in / result-out handshake bundle between decode, the execute unit and its consumer.
interface rformat_exec_unit_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 5
);
    import rformat_pkg::*;

    logic              in_valid;
    logic              in_ready;
    alu_op_t           alu_op;
    logic [AW-1:0]     rs_addr;
    logic [AW-1:0]     rt_addr;
    logic [AW-1:0]     rd_addr;
    logic              res_valid;
    logic              res_ready;
    logic [AW-1:0]     res_addr;
    logic [DATA_W-1:0] res_data;

    modport master (
        output in_valid, alu_op, rs_addr, rt_addr, rd_addr, res_ready,
        input  in_ready, res_valid, res_addr, res_data
    );

    modport slave (
        input  in_valid, alu_op, rs_addr, rt_addr, rd_addr, res_ready,
        output in_ready, res_valid, res_addr, res_data
    );

endinterface

// File: rtl/rformat_exec_unit_alu_core.sv
// Combinational R-format ALU; ovf reports signed overflow for ADD and SUB only.
module alu_core import rformat_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  alu_op_t                  op,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] result,
    output logic                     ovf
);

    logic signed [DATA_W-1:0] sum;
    logic signed [DATA_W-1:0] diff;

    // Overflow when both addends share a sign that the result does not.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: begin
                result = sum;
                ovf    = add_ovf(a[DATA_W-1], b[DATA_W-1], sum[DATA_W-1]);
            end
            OP_XOR: result = a ^ b;
            OP_NOR: result = ~(a | b);
            OP_RSV: result = '0;
            OP_SUB: begin
                result = diff;
                ovf    = add_ovf(a[DATA_W-1], ~b[DATA_W-1], diff[DATA_W-1]);
            end
            OP_SLT: result = (a < b) ? DATA_W'(1) : '0;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rformat_exec_unit.sv
// R-format execute/writeback: regfile, ALU, one EX register with valid/ready and EX->read forwarding.
// Optional RFMT_OVF_TRAP_EN: signed ADD/SUB overflow suppresses the writeback and pulses ovf_flag.
module rformat_exec_unit import rformat_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int CNT_W  = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset_input,
    rformat_exec_unit_if.slave   bus,
    input  logic [AW-1:0]        dbg_addr,
    output logic [DATA_W-1:0]    dbg_data,
    output logic [CNT_W-1:0]     retired
`ifdef RFMT_OVF_TRAP_EN
    ,
    output logic                 ovf_flag
`endif
);

    logic [DATA_W-1:0]        regs [NREGS];

    logic signed [DATA_W-1:0] op_a_p0;
    logic signed [DATA_W-1:0] op_b_p0;
    logic signed [DATA_W-1:0] alu_res_p0;

    logic                     vld_p1;
    logic [AW-1:0]            res_addr_p1;
    logic signed [DATA_W-1:0] res_data_p1;

    logic                     accept;
    logic                     commit;
    logic                     wr_en;

    assign accept = bus.in_valid && bus.in_ready;
    assign commit = vld_p1 && bus.res_ready;

    assign bus.in_ready  = !vld_p1 || bus.res_ready;
    assign bus.res_valid = vld_p1;
    assign bus.res_addr  = res_addr_p1;
    assign bus.res_data  = res_data_p1;

    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

    // Read stage: the held EX result is newer than the regfile until it commits.
    assign op_a_p0 = (bus.rs_addr == '0)                      ? '0 :
                     (vld_p1 && bus.rs_addr == res_addr_p1)  ? res_data_p1 :
                                                                regs[bus.rs_addr];
    assign op_b_p0 = (bus.rt_addr == '0)                      ? '0 :
                     (vld_p1 && bus.rt_addr == res_addr_p1)  ? res_data_p1 :
                                                                regs[bus.rt_addr];

`ifdef RFMT_OVF_TRAP_EN
    logic alu_ovf_p0;
    logic ovf_p1;

    assign wr_en = commit && (res_addr_p1 != '0) && !ovf_p1;

    always_ff @(posedge clk or negedge reset_input) begin
        if (!reset_input) begin
            ovf_p1   <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (accept)
                ovf_p1 <= alu_ovf_p0;
            ovf_flag <= commit && ovf_p1;
        end
    end
`else
    logic alu_ovf_unused;

    assign wr_en = commit && (res_addr_p1 != '0);
`endif

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .op     (bus.alu_op),
        .a      (op_a_p0),
        .b      (op_b_p0),
        .result (alu_res_p0),
`ifdef RFMT_OVF_TRAP_EN
        .ovf    (alu_ovf_p0)
`else
        .ovf    (alu_ovf_unused)
`endif
    );

    // EX stage: a simultaneous commit and accept reloads the register in place.
    always_ff @(posedge clk or negedge reset_input) begin
        if (!reset_input) begin
            vld_p1      <= 1'b0;
            res_addr_p1 <= '0;
            res_data_p1 <= '0;
        end else if (accept) begin
            vld_p1      <= 1'b1;
            res_addr_p1 <= bus.rd_addr;
            res_data_p1 <= alu_res_p0;
        end else if (commit) begin
            vld_p1      <= 1'b0;
        end
    end

    // Writeback stage
    always_ff @(posedge clk or negedge reset_input) begin
        if (!reset_input) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            retired <= '0;
        end else begin
            if (wr_en)
                regs[res_addr_p1] <= res_data_p1;
            if (commit)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rformat_exec_unit.sv
// Directed bench for rformat_exec_unit; builds constants from r0 via NOR/SUB/ADD since there is no load path.
module tb_rformat_exec_unit;
    import rformat_pkg::*;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int CNT_W  = 16;
    localparam int AW     = 5;

    logic              clk = 1'b0;
    logic              reset_input = 1'b0;
    logic [AW-1:0]     dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [CNT_W-1:0]  retired;
`ifdef RFMT_OVF_TRAP_EN
    logic              ovf_flag;
`endif

    int n_chk   = 0;
    int n_err   = 0;
    int exp_ret = 0;

    always #5 clk = ~clk;

    rformat_exec_unit_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

    rformat_exec_unit #(.DATA_W(DATA_W), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_input (reset_input),
        .bus         (bus),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .retired     (retired)
`ifdef RFMT_OVF_TRAP_EN
        ,
        .ovf_flag    (ovf_flag)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_instr(input alu_op_t op, input int rd, input int rs, input int rt);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.rd_addr  = AW'(rd);
        bus.rs_addr  = AW'(rs);
        bus.rt_addr  = AW'(rt);
    endtask

    // Issue one instruction (accepted at the next edge) and check the EX result.
    task automatic run(input alu_op_t op, input int rd, input int rs, input int rt,
                       input logic [31:0] exp, input string tag);
        set_instr(op, rd, rs, rt);
        @(posedge clk); #1;
        exp_ret++;
        chk(tag, bus.res_data, exp);
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_reg(input int addr, input logic [31:0] exp, input string tag);
        dbg_addr = AW'(addr);
        #1;
        chk(tag, dbg_data, exp);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        bus.alu_op    = OP_AND;
        bus.rd_addr   = '0;
        bus.rs_addr   = '0;
        bus.rt_addr   = '0;
        dbg_addr      = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_retired", 32'(retired), 32'd0);
        for (int i = 0; i < NREGS; i++)
            chk_reg(i, 32'd0, "rst_reg");
        reset_input = 1'b1;
        @(posedge clk); #1;

        run(OP_NOR, 10, 0, 0, 32'hFFFF_FFFF, "nor_m1");
        run(OP_SUB, 11, 0, 10, 32'd1, "sub_one");
        run(OP_ADD, 12, 11, 11, 32'd2, "add_two");
        run(OP_ADD, 13, 12, 12, 32'd4, "add_four");
        run(OP_ADD, 1, 13, 11, 32'd5, "r1_five");
        run(OP_ADD, 2, 1, 12, 32'd7, "r2_seven");
        run(OP_ADD, 3, 1, 2, 32'd12, "add_r3");
        run(OP_SUB, 4, 3, 1, 32'd7, "sub_fwd");
        drain();
        chk_reg(3, 32'd12, "reg_r3");
        chk_reg(4, 32'd7, "reg_r4");
        chk("retired_8", 32'(retired), 32'(exp_ret));

        // Backpressure: AND held while OR waits at the input.
        bus.res_ready = 1'b0;
        run(OP_AND, 6, 3, 4, 32'd4, "and_held");
        set_instr(OP_OR, 7, 3, 4);
        dbg_addr = AW'(6);
        #1;
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_res_data", bus.res_data, 32'd4);
            chk("bp_res_addr", 32'(bus.res_addr), 32'd6);
            chk("bp_reg_r6", dbg_data, 32'd0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        exp_ret++;
        chk("bp_or_loaded", bus.res_data, 32'd15);
        chk("bp_reg_r6_commit", dbg_data, 32'd4);
        drain();
        chk_reg(7, 32'd15, "reg_r7");

        run(OP_ADD, 0, 1, 2, 32'd12, "add_r0");
        chk("add_r0_addr", 32'(bus.res_addr), 32'd0);
        run(OP_XOR, 8, 3, 4, 32'd11, "xor");
        run(OP_RSV, 9, 3, 4, 32'd0, "reserved");
        run(OP_SLT, 5, 10, 11, 32'd1, "slt_true");
        run(OP_SLT, 20, 11, 10, 32'd0, "slt_false");
        drain();
        chk_reg(0, 32'd0, "reg_r0");
        chk_reg(5, 32'd1, "reg_r5");
        chk_reg(8, 32'd11, "reg_r8");
        chk("retired_mid", 32'(retired), 32'(exp_ret));

        // Build 0x7FFFFFFF without ever overflowing, then push it over the edge.
        run(OP_ADD, 16, 11, 0, 32'd1, "pow_seed");
        for (int k = 1; k <= 30; k++)
            run(OP_ADD, 16, 16, 16, 32'h1 << k, "pow_double");
        run(OP_SUB, 17, 16, 11, 32'h3FFF_FFFF, "sub_3fff");
        run(OP_ADD, 18, 16, 17, 32'h7FFF_FFFF, "max_pos");
        run(OP_ADD, 19, 18, 11, 32'h8000_0000, "wrap_add");
        drain();
`ifdef RFMT_OVF_TRAP_EN
        chk("ovf_pulse", 32'(ovf_flag), 32'd1);
        chk_reg(19, 32'd0, "ovf_reg_kept");
        @(posedge clk); #1;
        chk("ovf_clear", 32'(ovf_flag), 32'd0);
`else
        chk_reg(19, 32'h8000_0000, "wrap_reg");
`endif
        chk_reg(18, 32'h7FFF_FFFF, "reg_r18");
        chk("retired_end", 32'(retired), 32'(exp_ret));

        // Reset in the middle of a held result drops it.
        bus.res_ready = 1'b0;
        run(OP_ADD, 21, 1, 2, 32'd12, "pre_reset");
        bus.in_valid = 1'b0;
        reset_input = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_rst_retired", 32'(retired), 32'd0);
        chk_reg(3, 32'd0, "mid_rst_reg");
        #3;
        reset_input = 1'b1;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(bus.res_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
